// File: rtl/dot_vec_pipe.sv
// Pipelined signed fixed-point dot product with lossless, credit-controlled output buffer.
// Products, adder tree and final scaling each take one register stage ahead of the buffer.
module dot_vec_pipe #(
  parameter int VEC_LEN    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int Q_BITS     = 10,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 1,
  parameter int OUT_DEPTH  = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [VEC_LEN*DATA_WIDTH-1:0] x,
  input  logic [VEC_LEN*DATA_WIDTH-1:0] y,
  input  logic                          in_empty,
  output logic                          in_rd_en,
  output logic [DATA_WIDTH-1:0]         out,
  output logic                          out_ovf,
  output logic                          out_empty,
  input  logic                          out_rd_en,
  output logic [$clog2(OUT_DEPTH):0]    count
);

  localparam int W      = DATA_WIDTH;
  localparam int LEVELS = $clog2(VEC_LEN);
  localparam int P      = 1 << LEVELS;
  localparam int SW     = 2 * W + LEVELS;
  localparam int AW     = $clog2(OUT_DEPTH);
  localparam int UW     = AW + 4;

  localparam logic [SW-1:0] HALF = (ROUND != 0) ? (SW'(1) << (Q_BITS - 1)) : '0;
  localparam logic signed [SW-1:0] MAXV = {{(SW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW - W + 1){1'b1}}, {(W - 1){1'b0}}};

  logic signed [2*W-1:0] prod [P];
  logic [P-1:0][SW-1:0]  lvl [LEVELS+1];
  logic [LEVELS:0]       vld;

  logic                  fin_vld;
  logic [W-1:0]          fin_data;
  logic                  fin_ovf;

  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  rnd;
  logic signed [SW-1:0]  shf;
  logic                  res_ovf;
  logic [W-1:0]          res_data;

  logic [W-1:0]          mem_data [OUT_DEPTH];
  logic                  mem_ovf  [OUT_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic [UW-1:0]         used;

  // Lanes beyond VEC_LEN are held at zero so the tree is always a full power of two.
  always_comb begin
    for (int i = 0; i < P; i++) prod[i] = '0;
    for (int i = 0; i < VEC_LEN; i++)
      prod[i] = (2*W)'($signed(x[i*W +: W])) * (2*W)'($signed(y[i*W +: W]));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int l = 0; l <= LEVELS; l++) lvl[l] <= '0;
    end else begin
      vld[0] <= in_rd_en;
      for (int l = 1; l <= LEVELS; l++) vld[l] <= vld[l-1];
      for (int j = 0; j < P; j++) lvl[0][j] <= SW'(prod[j]);
      for (int l = 1; l <= LEVELS; l++) begin
        for (int j = 0; j < P / 2; j++) lvl[l][j] <= lvl[l-1][2*j] + lvl[l-1][2*j+1];
        for (int j = P / 2; j < P; j++) lvl[l][j] <= '0;
      end
    end
  end

  always_comb begin
    sum      = $signed(lvl[LEVELS][0]);
    rnd      = sum + $signed(HALF);
    shf      = rnd >>> Q_BITS;
    res_ovf  = (shf > MAXV) || (shf < MINV);
    res_data = shf[W-1:0];
    if (res_ovf && (SATURATE != 0)) res_data = shf[SW-1] ? MINV[W-1:0] : MAXV[W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fin_vld  <= 1'b0;
      fin_data <= '0;
      fin_ovf  <= 1'b0;
    end else begin
      fin_vld  <= vld[LEVELS];
      fin_data <= res_data;
      fin_ovf  <= res_ovf;
    end
  end

  // Every in-flight stage holds a reserved buffer slot, so the buffer can never overflow.
  always_comb begin
    used = UW'(count) + UW'(fin_vld);
    for (int l = 0; l <= LEVELS; l++) used = used + UW'(vld[l]);
  end

  assign in_rd_en  = reset && !in_empty && (used < UW'(OUT_DEPTH));
  assign out_empty = (count == '0);
  assign full      = (count == (AW+1)'(OUT_DEPTH));
  assign push      = fin_vld;
  assign pop       = out_rd_en && !out_empty;
  assign out       = out_empty ? '0 : mem_data[rd_ptr];
  assign out_ovf   = out_empty ? 1'b0 : mem_ovf[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= fin_data;
      mem_ovf[wr_ptr]  <= fin_ovf;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset && push) assert (!full);
  end

endmodule

// File: tb/tb_dot_vec_pipe.sv
// Directed and random checks of dot_vec_pipe; u_dut is truncate/saturate, u_alt is round/wrap.
module tb_dot_vec_pipe;

  localparam int W = 32;
  localparam int N = 3;
  localparam int LAT = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N*W-1:0] x = '0;
  logic [N*W-1:0] y = '0;
  logic           in_empty = 1'b1;
  logic           out_rd_en = 1'b0;
  logic           in_rd_en, out_ovf, out_empty;
  logic [W-1:0]   out;
  logic [3:0]     count;
  logic           a_in_rd_en, a_out_ovf, a_out_empty;
  logic [W-1:0]   a_out;
  logic [3:0]     a_count;

  int vectors = 0;
  int errors  = 0;

  dot_vec_pipe #(.VEC_LEN(N), .DATA_WIDTH(W), .Q_BITS(10), .ROUND(0), .SATURATE(1), .OUT_DEPTH(8)) u_dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .out(out), .out_ovf(out_ovf), .out_empty(out_empty), .out_rd_en(out_rd_en), .count(count)
  );

  dot_vec_pipe #(.VEC_LEN(N), .DATA_WIDTH(W), .Q_BITS(10), .ROUND(1), .SATURATE(0), .OUT_DEPTH(8)) u_alt (
    .clock(clock), .reset(reset), .x(x), .y(y), .in_empty(in_empty), .in_rd_en(a_in_rd_en),
    .out(a_out), .out_ovf(a_out_ovf), .out_empty(a_out_empty), .out_rd_en(out_rd_en), .count(a_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [W-1:0] model(input logic [N*W-1:0] xv, input logic [N*W-1:0] yv,
                                         input bit rnd, input bit sat, output bit ovf);
    logic signed [67:0] acc;
    logic signed [67:0] sh;
    acc = '0;
    for (int i = 0; i < N; i++)
      acc = acc + 68'($signed(xv[i*W +: W])) * 68'($signed(yv[i*W +: W]));
    if (rnd) acc = acc + 68'sd512;
    sh  = acc >>> 10;
    ovf = (sh > 68'sd2147483647) || (sh < -68'sd2147483648);
    if (ovf && sat) return sh[67] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return sh[31:0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_vec(input logic [N*W-1:0] xv, input logic [N*W-1:0] yv, output bit took);
    x = xv;
    y = yv;
    in_empty = 1'b0;
    #1;
    took = in_rd_en;
    @(posedge clock);
    #1;
    in_empty = 1'b1;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!out_empty) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pop_one();
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_empty = 1'b0;
    repeat (2) tick();
    vectors++; if (in_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_rd_en: got %b expected 0", in_rd_en); end
    vectors++; if (out_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_out_empty: got %b expected 1", out_empty); end
    vectors++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    vectors++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL reset_out: got %h expected 00000000", out); end
    vectors++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_ovf: got %b expected 0", out_ovf); end
    in_empty = 1'b1;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit took;
    send_vec({32'h0000_0C00, 32'h0000_0800, 32'h0000_0400}, {3{32'h0000_0400}}, took);
    vectors++; if (took !== 1'b1) begin errors++; $display("[TB] FAIL basic_accept: got %b expected 1", took); end
    // Accepted on edge t; the buffer must fill on edge t+LAT, not earlier.
    for (int k = 0; k <= LAT; k++) begin
      vectors++;
      if (out_empty !== (k < LAT)) begin
        errors++; $display("[TB] FAIL basic_latency_%0d: got out_empty=%b expected %b", k, out_empty, (k < LAT));
      end
      if (k < LAT) tick();
    end
    vectors++; if (out !== 32'h0000_1800) begin errors++; $display("[TB] FAIL basic_out: got %h expected 00001800", out); end
    vectors++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %b expected 0", out_ovf); end
    vectors++; if (a_out !== 32'h0000_1800) begin errors++; $display("[TB] FAIL basic_alt_out: got %h expected 00001800", a_out); end
    pop_one();
    vectors++; if (out_empty !== 1'b1 || count !== 4'd0) begin
      errors++; $display("[TB] FAIL basic_pop: got empty=%b count=%0d expected empty=1 count=0", out_empty, count);
    end
  endtask

  task automatic test_sign();
    bit took, ok;
    send_vec({32'h0, 32'h0, 32'hFFFF_FC00}, {32'h0, 32'h0, 32'h0000_0400}, took);
    wait_out(ok);
    vectors++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL sign_timeout: got %b expected 1", ok); end
    vectors++; if (out !== 32'hFFFF_FC00) begin errors++; $display("[TB] FAIL sign_out: got %h expected fffffc00", out); end
    vectors++; if (a_out !== 32'hFFFF_FC00) begin errors++; $display("[TB] FAIL sign_alt_out: got %h expected fffffc00", a_out); end
    pop_one();
  endtask

  task automatic test_rounding();
    bit took, ok;
    send_vec({32'h0, 32'h0, 32'h0000_0001}, {32'h0, 32'h0, 32'h0000_0200}, took);
    wait_out(ok);
    vectors++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL round_timeout: got %b expected 1", ok); end
    vectors++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL round_trunc: got %h expected 00000000", out); end
    vectors++; if (a_out !== 32'h1) begin errors++; $display("[TB] FAIL round_half_up: got %h expected 00000001", a_out); end
    pop_one();
  endtask

  task automatic test_saturation();
    bit took, ok;
    send_vec({3{32'h7FFF_FFFF}}, {3{32'h7FFF_FFFF}}, took);
    wait_out(ok);
    vectors++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL sat_pos_timeout: got %b expected 1", ok); end
    vectors++; if (out !== 32'h7FFF_FFFF || out_ovf !== 1'b1) begin
      errors++; $display("[TB] FAIL sat_pos: got %h ovf=%b expected 7fffffff ovf=1", out, out_ovf);
    end
    vectors++; if (a_out !== 32'hFF40_0000 || a_out_ovf !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_pos: got %h ovf=%b expected ff400000 ovf=1", a_out, a_out_ovf);
    end
    pop_one();
    send_vec({3{32'h8000_0001}}, {3{32'h7FFF_FFFF}}, took);
    wait_out(ok);
    vectors++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL sat_neg_timeout: got %b expected 1", ok); end
    vectors++; if (out !== 32'h8000_0000 || out_ovf !== 1'b1) begin
      errors++; $display("[TB] FAIL sat_neg: got %h ovf=%b expected 80000000 ovf=1", out, out_ovf);
    end
    vectors++; if (a_out !== 32'h00C0_0000 || a_out_ovf !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_neg: got %h ovf=%b expected 00c00000 ovf=1", a_out, a_out_ovf);
    end
    pop_one();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int rcv = 0;
    bit took;
    logic [W-1:0] exp_v;
    y = {32'h0, 32'h0, 32'h0000_0400};
    out_rd_en = 1'b0;
    for (int it = 0; it < 16; it++) begin
      x = {64'h0, 32'((idx + 1) * 1024)};
      in_empty = (idx >= 20);
      #1;
      took = in_rd_en;
      tick();
      if (took) idx++;
    end
    x = {64'h0, 32'((idx + 1) * 1024)};
    in_empty = 1'b0;
    #1;
    vectors++; if (idx !== 8) begin errors++; $display("[TB] FAIL bp_accepted: got %0d expected 8", idx); end
    vectors++; if (in_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_rd_en: got %b expected 0", in_rd_en); end
    vectors++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 8", count); end
    vectors++; if (a_count !== 4'd8) begin errors++; $display("[TB] FAIL bp_alt_count: got %0d expected 8", a_count); end
    tick();
    out_rd_en = 1'b1;
    for (int it = 0; it < 80 && rcv < 20; it++) begin
      x = {64'h0, 32'((idx + 1) * 1024)};
      in_empty = (idx >= 20);
      #1;
      if (!out_empty) begin
        exp_v = 32'((rcv + 1) * 1024);
        vectors++; if (out !== exp_v || a_out !== exp_v) begin
          errors++; $display("[TB] FAIL bp_drain_%0d: got %h/%h expected %h", rcv, out, a_out, exp_v);
        end
        rcv++;
      end
      took = in_rd_en;
      tick();
      if (took) idx++;
    end
    out_rd_en = 1'b0;
    in_empty = 1'b1;
    vectors++; if (rcv !== 20 || idx !== 20) begin
      errors++; $display("[TB] FAIL bp_complete: got rcv=%0d idx=%0d expected 20/20", rcv, idx);
    end
    vectors++; if (out_empty !== 1'b1) begin errors++; $display("[TB] FAIL bp_final_empty: got %b expected 1", out_empty); end
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] xs [100];
    logic [N*W-1:0] ys [100];
    logic [W-1:0]   ed [100];
    logic [W-1:0]   ea [100];
    bit             od [100];
    bit             oa [100];
    int idx = 0;
    int rcv = 0;
    int iters = 0;
    bit took;
    logic [W-1:0] ex, ey;
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < N; i++) begin
        ex = $urandom;
        ey = $urandom;
        if (k % 2 == 0) begin
          ex = {{16{ex[15]}}, ex[15:0]};
          ey = {{16{ey[15]}}, ey[15:0]};
        end
        xs[k][i*W +: W] = ex;
        ys[k][i*W +: W] = ey;
      end
      ed[k] = model(xs[k], ys[k], 1'b0, 1'b1, od[k]);
      ea[k] = model(xs[k], ys[k], 1'b1, 1'b0, oa[k]);
    end
    out_rd_en = 1'b1;
    while (rcv < 100 && iters < 100 + LAT + 1) begin
      x = xs[(idx < 100) ? idx : 0];
      y = ys[(idx < 100) ? idx : 0];
      in_empty = (idx >= 100);
      #1;
      if (!out_empty) begin
        vectors++; if (out !== ed[rcv] || out_ovf !== od[rcv]) begin
          errors++; $display("[TB] FAIL stream_%0d: got %h ovf=%b expected %h ovf=%b", rcv, out, out_ovf, ed[rcv], od[rcv]);
        end
        vectors++; if (a_out !== ea[rcv] || a_out_ovf !== oa[rcv]) begin
          errors++; $display("[TB] FAIL stream_alt_%0d: got %h ovf=%b expected %h ovf=%b", rcv, a_out, a_out_ovf, ea[rcv], oa[rcv]);
        end
        rcv++;
      end
      took = in_rd_en;
      tick();
      if (took) idx++;
      iters++;
    end
    out_rd_en = 1'b0;
    in_empty = 1'b1;
    vectors++; if (rcv !== 100 || idx !== 100) begin
      errors++; $display("[TB] FAIL stream_complete: got rcv=%0d idx=%0d expected 100/100 in %0d cycles", rcv, idx, 100 + LAT);
    end
  endtask

  task automatic test_reset_midstream();
    bit took, ok;
    int stale = 0;
    out_rd_en = 1'b0;
    x = {32'h0000_0C00, 32'h0000_0800, 32'h0000_0400};
    y = {3{32'h0000_0400}};
    in_empty = 1'b0;
    repeat (6) tick();
    reset = 1'b0;
    #1;
    vectors++; if (out_empty !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_empty: got %b expected 1", out_empty); end
    vectors++; if (count !== 4'd0 || a_count !== 4'd0) begin
      errors++; $display("[TB] FAIL mid_reset_count: got %0d/%0d expected 0", count, a_count);
    end
    vectors++; if (in_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_in_rd_en: got %b expected 0", in_rd_en); end
    in_empty = 1'b1;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_empty || count != 0) stale++;
    end
    vectors++; if (stale !== 0) begin errors++; $display("[TB] FAIL mid_stale: got %0d stale cycles expected 0", stale); end
    send_vec({32'h0, 32'h0, 32'h0000_0800}, {32'h0, 32'h0, 32'h0000_0400}, took);
    wait_out(ok);
    vectors++; if (ok !== 1'b1 || out !== 32'h0000_0800 || count !== 4'd1) begin
      errors++; $display("[TB] FAIL mid_fresh: got ok=%b out=%h count=%0d expected ok=1 out=00000800 count=1", ok, out, count);
    end
    pop_one();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dot_vec_pipe.md
Name: dot_vec_pipe

Overview:
Parameterised, fully pipelined signed fixed-point dot product over VEC_LEN-element vectors. It generalises the 3-lane Q10 dot unit in width, length, rounding and saturation, and accepts one vector pair per cycle. It sits between two fifo_array input buffers and downstream consumers, using the same FIFO-style handshake on both sides. An internal output buffer plus credit counting makes backpressure lossless.

Parameters:
VEC_LEN, 3, number of elements per vector (1..16)
DATA_WIDTH, 32, signed two's-complement width of each element and of the result
Q_BITS, 10, fractional bits of inputs and result (0 < Q_BITS < DATA_WIDTH)
ROUND, 0, 0 = truncate toward -inf (arithmetic shift); 1 = round half up (add 2^(Q_BITS-1) before shift)
SATURATE, 1, 1 = clamp to DATA_WIDTH range; 0 = wrap (keep low DATA_WIDTH bits)
OUT_DEPTH, 8, result buffer entries (power of two, >= 2)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
x  in  VEC_LEN*DATA_WIDTH  vector x; element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
y  in  VEC_LEN*DATA_WIDTH  vector y; same packing as x
in_empty  in  1  upstream has no vector pair available
in_rd_en  out  1  pop one x/y pair this cycle
out  out  DATA_WIDTH  head-of-buffer result (first-word fall-through)
out_ovf  out  1  head result was saturated or wrapped
out_empty  out  1  result buffer empty
out_rd_en  in  1  consumer pops the head result this cycle
count  out  clog2(OUT_DEPTH)+1  results currently held in the buffer

Behaviour:
- Reset (reset=0, asynchronous): all pipeline valid bits cleared, buffer pointers = 0, count = 0, in_rd_en = 0, out_empty = 1, out = 0, out_ovf = 0. Any in-flight vectors are discarded, including on reset mid-stream.
- Accept: in_rd_en = !in_empty && (inflight + count < OUT_DEPTH), where inflight = number of valid pipeline stages. This is combinational, and x/y are sampled on the same edge.
- Pipeline: LAT = 2 + clog2(VEC_LEN) register stages.
  - S1: VEC_LEN signed products, each 2*DATA_WIDTH bits.
  - S2..S(1+clog2 VEC_LEN): binary adder tree, sign-extended to 2*DATA_WIDTH+clog2(VEC_LEN) bits. An odd leftover passes through; VEC_LEN=1 uses zero tree stages.
  - Final stage: optional rounding, then arithmetic shift right by Q_BITS, then saturate or wrap. The result is written into the buffer.
- Overflow: ovf=1 if the shifted sum lies outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. If SATURATE, out is clamped to 0x7FF..F or 0x800..0; otherwise the low bits are kept.
- Latency: a pair accepted at edge t makes out_empty=0 and out valid after edge t+LAT, if the buffer was empty.
- Throughput: 1 result/cycle sustained while out_rd_en keeps pace.
- Buffer: circular, OUT_DEPTH entries.
  - out_rd_en while out_empty is ignored (no pointer move).
  - Simultaneous write and pop leaves count unchanged.
  - Pointers wrap modulo OUT_DEPTH.
  - The credit rule guarantees no write ever reaches a full buffer. A write while full is a design error; an assertion is required in simulation.
- Ordering: results leave in strict acceptance order. There is no bubble insertion or reordering.

Test Plan:
- Basic, Q10 with VEC_LEN=3: x=(0x400,0x800,0xC00), y=(0x400,0x400,0x400) -> out=0x00001800, out_ovf=0, and out_empty falls exactly 4 edges after acceptance.
- Sign: x=(0xFFFFFC00,0,0), y=(0x400,0,0) -> out=0xFFFFFC00.
- Rounding: x=(1,0,0), y=(0x200,0,0) -> out=0 with ROUND=0 and out=1 with ROUND=1.
- Saturation: all elements 0x7FFFFFFF. SATURATE=1 -> out=0x7FFFFFFF, out_ovf=1. With x negated -> out=0x80000000, out_ovf=1. SATURATE=0 -> low 32 bits, out_ovf=1.
- Backpressure: out_rd_en=0 with 20 queued pairs -> exactly 8 accepted, in_rd_en=0 thereafter, count=8. Then out_rd_en=1 drains 20 correct results in order, with no loss or duplication.
- Streaming/reset:
  - 100 random back-to-back pairs complete in 100+LAT cycles and match the reference model.
  - Asserting reset mid-stream -> out_empty=1, count=0 immediately, and no stale results appear after release.
